layer_result_pingpong_mem: RTL and testbench

LAYER_RESULT_PINGPONG_MEM -- requirements
Module: layer_result_pingpong_mem

---
 rtl/layer_result_pingpong_mem.sv | 90 +++++++++
 tb/tb_layer_result_pingpong_mem.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/layer_result_pingpong_mem.sv
// Double-buffered layer-result store: the producer fills one bank while the consumer
// reads the other; banks swap on wr_done / rd_done handshakes.
module layer_result_pingpong_mem #(
  parameter int unsigned DATA_W = 128,
  parameter int unsigned ROWS   = 8,
  parameter int unsigned COLS   = 8,
  parameter int unsigned ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_row,
  input  logic [ADDR_W-1:0] wr_col,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_done,
  output logic              wr_ready,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_row,
  input  logic [ADDR_W-1:0] rd_col,
  input  logic              rd_done,
  output logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              err
);

  localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned CW = (COLS > 1) ? $clog2(COLS) : 1;

  logic [DATA_W-1:0] mem [2][ROWS][COLS];
  logic [1:0]        full, full_n;
  logic              wp, rp;
  logic              wr_in, rd_in, wr_acc, rd_acc, commit, rel, err_set;

  assign wr_ready = !full[wp];
  assign rd_ready = full[rp];

  assign wr_in   = (wr_row < ADDR_W'(ROWS)) && (wr_col < ADDR_W'(COLS));
  assign rd_in   = (rd_row < ADDR_W'(ROWS)) && (rd_col < ADDR_W'(COLS));
  assign wr_acc  = wr_en && wr_ready && wr_in;
  assign rd_acc  = rd_en && rd_ready && rd_in;
  assign commit  = wr_done && wr_ready;
  assign rel     = rd_done && rd_ready;
  assign err_set = (wr_en && (!wr_ready || !wr_in)) || (rd_en && (!rd_ready || !rd_in)) ||
                   (wr_done && !wr_ready) || (rd_done && !rd_ready);

  // Commit and release can never target the same bank: wr_ready and rd_ready imply wp != rp.
  always_comb begin
    full_n = full;
    if (commit) full_n[wp] = 1'b1;
    if (rel)    full_n[rp] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full <= 2'b00;
      wp   <= 1'b0;
      rp   <= 1'b0;
      err  <= 1'b0;
    end else begin
      full <= full_n;
      if (commit) wp <= !wp;
      if (rel)    rp <= !rp;
      if (err_set) err <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < 2; b++)
        for (int r = 0; r < ROWS; r++)
          for (int c = 0; c < COLS; c++)
            mem[b][r][c] <= '0;
    end else if (wr_acc) begin
      mem[wp][wr_row[RW-1:0]][wr_col[CW-1:0]] <= wr_data;
    end
  end

  // Read port returns zero on idle cycles so stale data never leaks out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_acc;
      rd_data  <= rd_acc ? mem[rp][rd_row[RW-1:0]][rd_col[CW-1:0]] : '0;
    end
  end

endmodule

// File: tb/tb_layer_result_pingpong_mem.sv
// Bench for layer_result_pingpong_mem: directed vector table, corner-case sequences
// and randomized traffic against a bank/flag reference model.
module tb_layer_result_pingpong_mem;

  localparam int unsigned DATA_W = 128;
  localparam int unsigned ROWS   = 8;
  localparam int unsigned COLS   = 8;
  localparam int unsigned ADDR_W = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              wr_en = 1'b0, wr_done = 1'b0, rd_en = 1'b0, rd_done = 1'b0;
  logic [ADDR_W-1:0] wr_row = '0, wr_col = '0, rd_row = '0, rd_col = '0;
  logic [DATA_W-1:0] wr_data = '0;
  logic              wr_ready, rd_ready, rd_valid, err;
  logic [DATA_W-1:0] rd_data;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state
  logic [DATA_W-1:0] m_mem [2][ROWS][COLS];
  bit   [1:0]        m_full;
  int                m_wp, m_rp;
  bit                m_err;
  bit                m_valid;
  logic [DATA_W-1:0] m_data;

  typedef struct {
    logic we; int wr; int wc; logic [DATA_W-1:0] wdat; logic wd;
    logic re; int rr; int rc; logic rdd;
    logic e_valid; logic [DATA_W-1:0] e_data; logic e_wrr; logic e_rdr; logic e_err;
  } vec_t;
  vec_t tbl [10];

  layer_result_pingpong_mem #(.DATA_W(DATA_W), .ROWS(ROWS), .COLS(COLS), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data),
    .wr_done(wr_done), .wr_ready(wr_ready),
    .rd_en(rd_en), .rd_row(rd_row), .rd_col(rd_col), .rd_done(rd_done),
    .rd_ready(rd_ready), .rd_data(rd_data), .rd_valid(rd_valid), .err(err)
  );

  always #5 clk = ~clk;

  function automatic bit m_wrr();
    return !m_full[m_wp];
  endfunction

  function automatic bit m_rdr();
    return m_full[m_rp];
  endfunction

  task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int b = 0; b < 2; b++)
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++)
          m_mem[b][r][c] = '0;
    m_full = 2'b00; m_wp = 0; m_rp = 0; m_err = 0; m_valid = 0; m_data = '0;
  endtask

  task automatic do_reset();
    wr_en = 0; wr_done = 0; rd_en = 0; rd_done = 0;
    rst = 1'b1;
    #1;
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_err", err, 0);
    chk("rst_wr_ready", wr_ready, 1);
    chk("rst_rd_ready", rd_ready, 0);
    model_clear();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // One clock: drive inputs, advance the model, then compare all outputs.
  task automatic cycle(input logic we, input int wr, input int wc, input logic [DATA_W-1:0] wdat,
                       input logic wd, input logic re, input int rr, input int rc, input logic rdd);
    bit w_in, r_in, w_ok, r_ok, wrr, rdr;
    wr_en = we; wr_row = ADDR_W'(wr); wr_col = ADDR_W'(wc); wr_data = wdat; wr_done = wd;
    rd_en = re; rd_row = ADDR_W'(rr); rd_col = ADDR_W'(rc); rd_done = rdd;
    wrr  = m_wrr();
    rdr  = m_rdr();
    w_in = (wr < ROWS) && (wc < COLS);
    r_in = (rr < ROWS) && (rc < COLS);
    w_ok = we && wrr && w_in;
    r_ok = re && rdr && r_in;
    if ((we && !(wrr && w_in)) || (re && !(rdr && r_in)) || (wd && !wrr) || (rdd && !rdr))
      m_err = 1;
    m_valid = r_ok;
    m_data  = r_ok ? m_mem[m_rp][rr][rc] : '0;
    if (w_ok) m_mem[m_wp][wr][wc] = wdat;
    if (wd && wrr) begin m_full[m_wp] = 1; m_wp = 1 - m_wp; end
    if (rdd && rdr) begin m_full[m_rp] = 0; m_rp = 1 - m_rp; end
    @(posedge clk); #1;
    chk("rd_valid", rd_valid, m_valid);
    chk("rd_data", rd_data, m_data);
    chk("err", err, m_err);
    chk("wr_ready", wr_ready, m_wrr());
    chk("rd_ready", rd_ready, m_rdr());
  endtask

  task automatic idle();
    cycle(0, 0, 0, '0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    model_clear();
    // Directed vectors after bank 0 is filled with row*COLS+col
    tbl[0] = '{1'b0, 0, 0, 128'h0,    1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 128'd0,      1'b1, 1'b1, 1'b0};
    tbl[1] = '{1'b0, 0, 0, 128'h0,    1'b0, 1'b1, 2, 3, 1'b0, 1'b1, 128'd19,     1'b1, 1'b1, 1'b0};
    tbl[2] = '{1'b0, 0, 0, 128'h0,    1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 128'd0,      1'b1, 1'b1, 1'b0};
    tbl[3] = '{1'b0, 0, 0, 128'h0,    1'b0, 1'b1, 7, 7, 1'b0, 1'b1, 128'd63,     1'b1, 1'b1, 1'b0};
    tbl[4] = '{1'b1, 0, 0, 128'hAAAA, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 128'd0,      1'b0, 1'b1, 1'b0};
    tbl[5] = '{1'b1, 1, 1, 128'hDEAD, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 128'd0,      1'b0, 1'b1, 1'b1};
    tbl[6] = '{1'b0, 0, 0, 128'h0,    1'b0, 1'b1, 1, 1, 1'b0, 1'b1, 128'd9,      1'b0, 1'b1, 1'b1};
    tbl[7] = '{1'b0, 0, 0, 128'h0,    1'b0, 1'b0, 0, 0, 1'b1, 1'b0, 128'd0,      1'b1, 1'b1, 1'b1};
    tbl[8] = '{1'b0, 0, 0, 128'h0,    1'b0, 1'b1, 0, 0, 1'b0, 1'b1, 128'hAAAA,   1'b1, 1'b1, 1'b1};
    tbl[9] = '{1'b0, 0, 0, 128'h0,    1'b0, 1'b1, 0, 1, 1'b0, 1'b1, 128'd0,      1'b1, 1'b1, 1'b1};

    #2;
    do_reset();

    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        cycle(1, r, c, DATA_W'(r * COLS + c), 0, 0, 0, 0, 0);

    for (int i = 0; i < 10; i++) begin
      cycle(tbl[i].we, tbl[i].wr, tbl[i].wc, tbl[i].wdat, tbl[i].wd,
            tbl[i].re, tbl[i].rr, tbl[i].rc, tbl[i].rdd);
      chk($sformatf("vec%0d_rd_valid", i), rd_valid, tbl[i].e_valid);
      chk($sformatf("vec%0d_rd_data", i), rd_data, tbl[i].e_data);
      chk($sformatf("vec%0d_wr_ready", i), wr_ready, tbl[i].e_wrr);
      chk($sformatf("vec%0d_rd_ready", i), rd_ready, tbl[i].e_rdr);
      chk($sformatf("vec%0d_err", i), err, tbl[i].e_err);
    end

    // Simultaneous release, commit and read of the bank being released
    do_reset();
    cycle(1, 0, 0, 128'h55, 1, 0, 0, 0, 0);
    cycle(0, 0, 0, '0, 1, 1, 0, 0, 1);
    chk("swap_rd_data", rd_data, 128'h55);
    chk("swap_rd_valid", rd_valid, 1);
    chk("swap_wr_ready", wr_ready, 1);
    chk("swap_rd_ready", rd_ready, 1);
    chk("swap_err", err, 0);
    cycle(1, 0, 0, 128'h77, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, '0, 0, 1, 0, 0, 0);
    chk("swap_bank1_data", rd_data, 0);

    // Out-of-range row must not alias onto row 0
    do_reset();
    cycle(1, ROWS, 0, 128'hBAD, 0, 0, 0, 0, 0);
    chk("oob_err", err, 1);
    cycle(1, 1, 0, 128'h5, 1, 0, 0, 0, 0);
    cycle(0, 0, 0, '0, 0, 1, 1, 0, 0);
    chk("oob_valid_read", rd_data, 128'h5);
    cycle(0, 0, 0, '0, 0, 1, 0, 0, 0);
    chk("oob_row0_untouched", rd_data, 0);

    // Reset asserted while read data is on the port
    do_reset();
    for (int i = 0; i < ROWS * COLS; i++)
      cycle(1, i / COLS, i % COLS, DATA_W'(256 + i), 0, 0, 0, 0, 0);
    cycle(0, 0, 0, '0, 1, 0, 0, 0, 0);
    cycle(0, 0, 0, '0, 0, 1, 3, 3, 0);
    chk("pre_rst_data", rd_data, DATA_W'(256 + 27));
    rst = 1'b1;
    #1;
    chk("midrst_rd_valid", rd_valid, 0);
    chk("midrst_rd_data", rd_data, 0);
    chk("midrst_wr_ready", wr_ready, 1);
    chk("midrst_rd_ready", rd_ready, 0);
    rd_en = 0;
    model_clear();
    @(posedge clk); #1;
    rst = 1'b0;
    cycle(1, 2, 2, 128'h99, 1, 0, 0, 0, 0);
    cycle(0, 0, 0, '0, 0, 1, 2, 2, 0);
    chk("postrst_new", rd_data, 128'h99);
    cycle(0, 0, 0, '0, 0, 1, 3, 3, 0);
    chk("postrst_old_gone", rd_data, 0);

    // Randomized traffic: even epochs stay legal, odd epochs include protocol errors
    for (int e = 0; e < 4; e++) begin
      do_reset();
      for (int n = 0; n < 500; n++) begin
        bit legal, we, wd, re, rdd;
        int wr, wc, rr, rc;
        legal = (e % 2) == 0;
        we  = 1'($urandom_range(0, 1));
        re  = 1'($urandom_range(0, 1));
        wd  = ($urandom_range(0, 9) == 0);
        rdd = ($urandom_range(0, 7) == 0);
        wr  = legal ? int'($urandom_range(0, ROWS - 1)) : int'($urandom_range(0, ROWS + 1));
        wc  = legal ? int'($urandom_range(0, COLS - 1)) : int'($urandom_range(0, COLS + 1));
        rr  = legal ? int'($urandom_range(0, ROWS - 1)) : int'($urandom_range(0, ROWS + 1));
        rc  = legal ? int'($urandom_range(0, COLS - 1)) : int'($urandom_range(0, COLS + 1));
        if (legal) begin
          we  = we  && m_wrr();
          wd  = wd  && m_wrr();
          re  = re  && m_rdr();
          rdd = rdd && m_rdr();
        end
        cycle(we, wr, wc, {$urandom, $urandom, $urandom, $urandom}, wd, re, rr, rc, rdd);
      end
      if (e % 2 == 0) chk("legal_epoch_no_err", err, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
